// File: rtl/store_buffer.sv
// Posted-write store buffer: aligns sw/sh/sb into word entries
// and drains them FIFO to data memory, stalling on full or load hit.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               memwrite,
   input  logic                     memread,
   input  logic [31:0]              dataadr,
   input  logic [31:0]              writedata,
   output logic                     stall,
   output logic                     misalign_err,
   output logic                     mem_we,
   output logic [31:0]              mem_adr,
   output logic [31:0]              mem_wd,
   output logic [3:0]               mem_be,
   input  logic                     mem_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [29:0] adr;
      logic [3:0]  be;
      logic [31:0] wd;
   } entry_t;

   entry_t        fifo [DEPTH];
   entry_t        new_e;
   entry_t        head_e;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] idx;
   logic          aligned;
   logic          store_req;
   logic          full;
   logic          ld_hit;
   logic          push;
   logic          pop;

   always_comb begin
      new_e     = '0;
      aligned   = 1'b0;
      new_e.adr = dataadr[31:2];
      case (memwrite)
         2'b01: begin
            aligned  = (dataadr[1:0] == 2'b00);
            new_e.be = 4'b1111;
            new_e.wd = writedata;
         end
         2'b10: begin
            aligned  = !dataadr[0];
            new_e.be = dataadr[1] ? 4'b1100 : 4'b0011;
            new_e.wd = {2{writedata[15:0]}};
         end
         2'b11: begin
            aligned  = 1'b1;
            new_e.be = 4'b0001 << dataadr[1:0];
            new_e.wd = {4{writedata[7:0]}};
         end
         default: ;
      endcase
   end

   // only the count entries starting at head are live
   always_comb begin
      ld_hit = 1'b0;
      idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + AW'(i);
         if (CW'(i) < count && fifo[idx].adr == dataadr[31:2])
            ld_hit = 1'b1;
      end
   end

   assign store_req = (memwrite != 2'b00) && aligned;
   assign full      = (count == CW'(DEPTH));
   assign push      = store_req && !full;
   assign pop       = mem_we && mem_ready;

   assign stall = !reset &&
                  ((store_req && full) ||
                   (memread && memwrite == 2'b00 && ld_hit));

   assign head_e  = fifo[head];
   assign mem_we  = (count != '0);
   assign mem_adr = mem_we ? {head_e.adr, 2'b00} : '0;
   assign mem_wd  = mem_we ? head_e.wd : '0;
   assign mem_be  = mem_we ? head_e.be : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         count        <= '0;
         head         <= '0;
         tail         <= '0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= (memwrite != 2'b00) && !aligned;
         if (push)
            tail <= tail + AW'(1);
         if (pop)
            head <= head + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // payload storage needs no reset; validity lives in count
   always_ff @(posedge clk) begin
      if (!reset && push)
         fifo[tail] <= new_e;
   end

endmodule
